// File: rtl/ha_pkg.sv
// Shared constants for the half-adder block: default counter width and counter maximum.
package ha_pkg;

    localparam int          CNT_W_DEF   = 16;
    localparam logic [31:0] CNT_MAX_DEF = 32'h0000_FFFF;

    // All-ones value of a w-bit counter, w in 1..32.
    function automatic logic [31:0] cnt_max(input int w);
        if (w >= 32)
            return 32'hFFFF_FFFF;
        else
            return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/ha_cell.sv
// Purely combinational half-adder cell: {c,s} = a + b, zero latency, no flow control.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/ha.sv
// Half adder with combinational s/c, one-cycle registered s_q/c_q/out_vld and saturating event counters.
// No backpressure: every in_vld pair is accepted; cnt_clr wins over a same-edge increment.
module ha
    import ha_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_vld,
    input  logic             cnt_clr,
    output logic             s,
    output logic             c,
    output logic             s_q,
    output logic             c_q,
    output logic             out_vld,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] sum_cnt
);

    localparam logic [31:0]      CNT_MAX_W = cnt_max(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];

    logic s_w;
    logic c_w;

    ha_cell u_cell (
        .a (a),
        .b (b),
        .s (s_w),
        .c (c_w)
    );

    assign s = s_w;
    assign c = c_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= 1'b0;
            c_q     <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                s_q <= s_w;
                c_q <= c_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
            sum_cnt   <= '0;
        end else if (cnt_clr) begin
            carry_cnt <= '0;
            sum_cnt   <= '0;
        end else if (in_vld) begin
            // Saturate: hold at all-ones instead of wrapping.
            if (c_w && (carry_cnt != CNT_MAX))
                carry_cnt <= carry_cnt + CNT_W'(1);
            if (s_w && (sum_cnt != CNT_MAX))
                sum_cnt <= sum_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ha.sv
// Self-checking bench for ha: combinational sweep, table-driven registered/counter vectors, saturation, async reset.
module tb_ha;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n = 1'b0;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic        in_vld = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        s, c, s_q, c_q, out_vld;
    logic [15:0] carry_cnt, sum_cnt;
    logic        s4, c4, s_q4, c_q4, out_vld4;
    logic [3:0]  carry_cnt4, sum_cnt4;

    int total = 0;
    int bad   = 0;

    ha dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_vld(in_vld), .cnt_clr(cnt_clr),
        .s(s), .c(c), .s_q(s_q), .c_q(c_q), .out_vld(out_vld),
        .carry_cnt(carry_cnt), .sum_cnt(sum_cnt)
    );

    ha #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_vld(in_vld), .cnt_clr(cnt_clr),
        .s(s4), .c(c4), .s_q(s_q4), .c_q(c_q4), .out_vld(out_vld4),
        .carry_cnt(carry_cnt4), .sum_cnt(sum_cnt4)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       a, b, vld, clr;
        logic       s, c;
        logic       sq, cq, ov;
        logic [15:0] ccnt, scnt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Combinational sweep with no clock, reset held low.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            a = ab[1];
            b = ab[0];
            #5;
            chk("sweep_s", {31'd0, s}, {31'd0, ab[1] ^ ab[0]});
            chk("sweep_c", {31'd0, c}, {31'd0, ab[1] & ab[0]});
            chk("sweep_sum", {30'd0, c, s}, 32'(ab[1]) + 32'(ab[0]));
            #5;
        end
        chk("rst_sq", {31'd0, s_q}, 32'd0);
        chk("rst_cq", {31'd0, c_q}, 32'd0);
        chk("rst_ov", {31'd0, out_vld}, 32'd0);
        chk("rst_ccnt", {16'd0, carry_cnt}, 32'd0);
        chk("rst_scnt", {16'd0, sum_cnt}, 32'd0);

        //          a     b     vld   clr   s     c     sq    cq    ov    ccnt   scnt
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 16'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd2};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 16'd2};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1};

        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; in_vld = vecs[i].vld; cnt_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_s", i), {31'd0, s}, {31'd0, vecs[i].s});
            chk($sformatf("v%0d_c", i), {31'd0, c}, {31'd0, vecs[i].c});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_sq", i), {31'd0, s_q}, {31'd0, vecs[i].sq});
            chk($sformatf("v%0d_cq", i), {31'd0, c_q}, {31'd0, vecs[i].cq});
            chk($sformatf("v%0d_ov", i), {31'd0, out_vld}, {31'd0, vecs[i].ov});
            chk($sformatf("v%0d_ccnt", i), {16'd0, carry_cnt}, {16'd0, vecs[i].ccnt});
            chk($sformatf("v%0d_scnt", i), {16'd0, sum_cnt}, {16'd0, vecs[i].scnt});
        end

        // Saturation: clear, then 20 accepted 11 pairs.
        @(negedge clk);
        cnt_clr = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b0; a = 1'b1; b = 1'b1; in_vld = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_c4", i), {28'd0, carry_cnt4}, (i > 15) ? 32'd15 : 32'(i));
            chk($sformatf("sat%0d_s4", i), {28'd0, sum_cnt4}, 32'd0);
            chk($sformatf("sat%0d_c16", i), {16'd0, carry_cnt}, 32'(i));
        end

        // Async reset between edges with nonzero state.
        @(negedge clk);
        a = 1'b1; b = 1'b0; in_vld = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_rst_ov", {31'd0, out_vld}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_sq", {31'd0, s_q}, 32'd0);
        chk("arst_cq", {31'd0, c_q}, 32'd0);
        chk("arst_ov", {31'd0, out_vld}, 32'd0);
        chk("arst_ccnt", {16'd0, carry_cnt}, 32'd0);
        chk("arst_scnt", {16'd0, sum_cnt}, 32'd0);
        chk("arst_ccnt4", {28'd0, carry_cnt4}, 32'd0);
        chk("arst_s", {31'd0, s}, 32'd1);
        chk("arst_c", {31'd0, c}, 32'd0);

        // Edge during reset discards the in-flight pair.
        @(posedge clk);
        #1;
        chk("inrst_sq", {31'd0, s_q}, 32'd0);
        chk("inrst_ov", {31'd0, out_vld}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 1'b1; b = 1'b1; in_vld = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_sq", {31'd0, s_q}, 32'd0);
        chk("post_rst_cq", {31'd0, c_q}, 32'd1);
        chk("post_rst_ov", {31'd0, out_vld}, 32'd1);
        chk("post_rst_ccnt", {16'd0, carry_cnt}, 32'd1);
        chk("post_rst_scnt", {16'd0, sum_cnt}, 32'd0);

        @(negedge clk);
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("final_hold_cq", {31'd0, c_q}, 32'd1);
        chk("final_ov", {31'd0, out_vld}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
